// File: rtl/boost_table_pkg.sv
// Shared definitions for the BOOST contingency-table path.
// Holds the table geometry, FIFO entry field positions, the FSM state encoding,
// and small helpers that decode a packed entry.
package boost_table_pkg;

  localparam int NUM_CELLS = 18;
  localparam logic [4:0] LAST_CELL = 5'd17;
  localparam int ENTRY_W = 6;
  localparam logic [1:0] GENO_MISSING = 2'd3;

  // Entry layout: {last, pheno, gA[1:0], gB[1:0]}
  localparam int LAST_BIT = 5;
  localparam int PHENO_BIT = 4;
  localparam int GA_LSB = 2;
  localparam int GB_LSB = 0;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Table cell addressed by an entry: pheno*9 + gA*3 + gB.
  function automatic logic [4:0] cell_index(input logic [ENTRY_W-1:0] e);
    logic [4:0] ga;
    logic [4:0] gb;
    ga = {3'd0, e[GA_LSB+:2]};
    gb = {3'd0, e[GB_LSB+:2]};
    return (e[PHENO_BIT] ? 5'd9 : 5'd0) + (ga * 5'd3) + gb;
  endfunction

  // Either genotype coded as missing means the entry must not be counted.
  function automatic logic geno_missing(input logic [ENTRY_W-1:0] e);
    return (e[GA_LSB+:2] == GENO_MISSING) || (e[GB_LSB+:2] == GENO_MISSING);
  endfunction

endpackage

// File: rtl/table_fifo_accumulator_if.sv
// Bus bundle between the table-build FIFO, the accumulator and the table consumer.
// master: accumulator side (drives pop request and the cell stream).
// slave : environment side (drives FIFO occupancy/data and out_ready).
interface table_fifo_accumulator_if #(
  parameter int DEPTH_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) ();
  import boost_table_pkg::*;

  logic [DEPTH_WIDTH:0] fifo_count;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic fifo_rd_en;
  logic out_valid;
  logic out_ready;
  logic [4:0] out_index;
  logic [CNT_WIDTH-1:0] out_count;
  logic out_last;
  logic busy;

  modport master (
    input fifo_count, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_index, out_count, out_last, busy
  );

  modport slave (
    output fifo_count, fifo_rd_data, out_ready,
    input fifo_rd_en, out_valid, out_index, out_count, out_last, busy
  );
endinterface

// File: rtl/sat_counter_bank.sv
// Bank of NUM_CELLS saturating counters forming one contingency table.
// Ports: clk/rst (sync, active high); inc_en/inc_idx bump one cell;
// clear zeroes the table (an increment in the same cycle lands on the cleared
// table); rd_idx/rd_data read a cell.
// rd_data returns the value the cell will hold after this edge, so a caller
// registering it sees the table including the update being applied right now.
module sat_counter_bank
  import boost_table_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [4:0]           inc_idx,
  input  logic                 clear,
  input  logic [4:0]           rd_idx,
  output logic [CNT_WIDTH-1:0] rd_data
);

  localparam logic [CNT_WIDTH-1:0] ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_r [NUM_CELLS];
  logic [CNT_WIDTH-1:0] cnt_next_s [NUM_CELLS];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // Next value of every cell: optional clear first, then optional saturating bump.
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      cnt_next_s[i] = (inc_en && (inc_idx == 5'(i)))
                      ? sat_inc(clear ? ZERO : cnt_r[i])
                      : (clear ? ZERO : cnt_r[i]);
    end
  end

  // Read mux over the post-update values.
  always_comb begin
    rd_data = ZERO;
    for (int i = 0; i < NUM_CELLS; i++) begin
      rd_data = (rd_idx == 5'(i)) ? cnt_next_s[i] : rd_data;
    end
  end

  // Counter storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cnt_r[i] <= ZERO;
      end
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/table_fifo_accumulator.sv
// Drain stage for the table-build FIFO: pops packed entries, accumulates them
// into an 18-cell saturating contingency table, and on a `last` entry streams
// the table out one cell per accepted handshake before clearing it.
// Ports: clk, rst (sync, active high); bus (master modport) carrying
// fifo_count/fifo_rd_data/fifo_rd_en and out_valid/out_ready/out_index/
// out_count/out_last/busy.
module table_fifo_accumulator
  import boost_table_pkg::*;
#(
  parameter int DEPTH_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  table_fifo_accumulator_if.master bus
);

  localparam logic [DEPTH_WIDTH:0] CNT_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] CNT_TWO = {{(DEPTH_WIDTH-1){1'b0}}, 2'b10};

  logic [0:0]           state_r;
  logic                 rd_en_r;
  logic                 rd_vld_r;
  logic                 pend_vld_r;
  logic [ENTRY_W-1:0]   pend_data_r;
  logic [4:0]           idx_r;
  logic                 out_valid_r;
  logic [CNT_WIDTH-1:0] out_count_r;
  logic                 out_last_r;
  logic                 busy_r;

  logic [0:0]           state_next_s;
  logic [4:0]           idx_next_s;
  logic                 inc_en_s;
  logic [4:0]           inc_idx_s;
  logic                 clear_s;
  logic                 exit_s;
  logic                 pop_ok_s;
  logic                 emit_next_s;
  logic [CNT_WIDTH-1:0] rd_data_s;

  sat_counter_bank #(.CNT_WIDTH(CNT_WIDTH)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (inc_en_s),
    .inc_idx (inc_idx_s),
    .clear   (clear_s),
    .rd_idx  (idx_next_s),
    .rd_data (rd_data_s)
  );

  // FSM next state, table update and emission index.
  always_comb begin
    state_next_s = state_r;
    idx_next_s = idx_r;
    inc_en_s = 1'b0;
    inc_idx_s = cell_index(bus.fifo_rd_data);
    clear_s = 1'b0;
    exit_s = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        idx_next_s = 5'd0;
        if (rd_vld_r) begin
          inc_en_s = !geno_missing(bus.fifo_rd_data);
          state_next_s = bus.fifo_rd_data[LAST_BIT] ? ST_EMIT : ST_ACCUM;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (out_valid_r && bus.out_ready) begin
          if (idx_r == LAST_CELL) begin
            // Table done: clear it and fold in the entry that arrived mid-emit.
            exit_s = 1'b1;
            clear_s = 1'b1;
            idx_next_s = 5'd0;
            inc_en_s = pend_vld_r && !geno_missing(pend_data_r);
            inc_idx_s = cell_index(pend_data_r);
            state_next_s = (pend_vld_r && pend_data_r[LAST_BIT]) ? ST_EMIT : ST_ACCUM;
          end else begin
            idx_next_s = idx_r + 5'd1;
          end
        end else begin
          idx_next_s = idx_r;
        end
      end
      default: begin
        state_next_s = ST_ACCUM;
        idx_next_s = 5'd0;
      end
    endcase
  end

  // fifo_count already excludes pops accepted before the last edge but not the
  // one being accepted now, so a lone remaining entry is only popped once.
  always_comb begin
    pop_ok_s = (bus.fifo_count >= CNT_TWO) || ((bus.fifo_count == CNT_ONE) && !rd_en_r);
    emit_next_s = (state_next_s == ST_EMIT);
  end

  // State, pop pipeline, pending entry and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
      rd_en_r <= 1'b0;
      rd_vld_r <= 1'b0;
      pend_vld_r <= 1'b0;
      pend_data_r <= {ENTRY_W{1'b0}};
      idx_r <= 5'd0;
      out_valid_r <= 1'b0;
      out_count_r <= {CNT_WIDTH{1'b0}};
      out_last_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      rd_en_r <= !emit_next_s && pop_ok_s;
      rd_vld_r <= rd_en_r;
      if (exit_s) begin
        pend_vld_r <= 1'b0;
      end else if ((state_r == ST_EMIT) && rd_vld_r) begin
        pend_vld_r <= 1'b1;
        pend_data_r <= bus.fifo_rd_data;
      end else begin
        pend_vld_r <= pend_vld_r;
      end
      out_valid_r <= emit_next_s;
      busy_r <= emit_next_s;
      idx_r <= emit_next_s ? idx_next_s : 5'd0;
      out_count_r <= emit_next_s ? rd_data_s : {CNT_WIDTH{1'b0}};
      out_last_r <= emit_next_s && (idx_next_s == LAST_CELL);
    end
  end

  assign bus.fifo_rd_en = rd_en_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_index = idx_r;
  assign bus.out_count = out_count_r;
  assign bus.out_last = out_last_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_table_fifo_accumulator.sv
// Bench for table_fifo_accumulator: a queue-based FIFO feeds packed entries,
// and a table-level model predicts every emitted cell stream.
module tb_table_fifo_accumulator;
  import boost_table_pkg::*;

  localparam int DW = 3;
  localparam int CW = 4;
  localparam int FDEPTH = 8;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct packed {
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic          last;
  } cell_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  table_fifo_accumulator_if #(.DEPTH_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  table_fifo_accumulator #(.DEPTH_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] src_q[$];
  logic [5:0] fifo_q[$];
  cell_t exp_q[$];
  logic [CW-1:0] mtab [NUM_CELLS];
  int ready_mode = 0;
  int feed_mode = 0;
  int pat_i = 0;
  logic [3:0] pat = 4'b1001;
  logic stalled_prev = 1'b0;
  cell_t prev_obs;
  int em_cycles = 0;
  int em_stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: entries between `last` flags form one table of saturating counts.
  task automatic push(input logic last, input logic p, input logic [1:0] ga, input logic [1:0] gb);
    int c;
    cell_t e;
    src_q.push_back({last, p, ga, gb});
    if (ga != 2'd3 && gb != 2'd3) begin
      c = (p ? 9 : 0) + int'(ga) * 3 + int'(gb);
      if (mtab[c] != CMAX) mtab[c] = mtab[c] + 1'b1;
    end
    if (last) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        e.idx = 5'(i);
        e.cnt = mtab[i];
        e.last = (i == NUM_CELLS - 1);
        exp_q.push_back(e);
        mtab[i] = '0;
      end
    end
  endtask

  task automatic step();
    cell_t obs;
    cell_t exp;
    logic pop;
    logic acc;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    obs.idx = bus.out_index;
    obs.cnt = bus.out_count;
    obs.last = bus.out_last;
    if (stalled_prev && !rst) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_hold", obs, prev_obs);
    end
    chk("no_pop_in_emit", bus.busy && bus.fifo_rd_en, 0);
    acc = bus.out_valid && bus.out_ready && !rst;
    if (acc) begin
      chk("busy_in_emit", bus.busy, 1);
      chk("cell_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk("cell", obs, exp);
      end
    end
    stalled_prev = bus.out_valid && !bus.out_ready && !rst;
    prev_obs = obs;
    if (bus.out_valid) begin
      em_cycles++;
      if (!bus.out_ready) em_stalls++;
    end
    pop = bus.fifo_rd_en && !rst;
    @(posedge clk);
    #1;
    if (pop) begin
      chk("no_overread", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) bus.fifo_rd_data = fifo_q.pop_front();
    end
    if (feed_mode == 0) begin
      while (src_q.size() != 0 && fifo_q.size() < FDEPTH) fifo_q.push_back(src_q.pop_front());
    end else if (src_q.size() != 0 && fifo_q.size() < FDEPTH && $urandom_range(0, 1) == 1) begin
      fifo_q.push_back(src_q.pop_front());
    end
    bus.fifo_count = (DW+1)'(fifo_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_CELLS; i++) mtab[i] = '0;
    stalled_prev = 1'b0;
    bus.fifo_rd_data = 6'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic drain(input int max, input string tag);
    int n;
    n = 0;
    while (!(src_q.size() == 0 && fifo_q.size() == 0 && exp_q.size() == 0 &&
             !bus.out_valid && !bus.busy) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, n < max, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk({tag, "_quiet_valid"}, bus.out_valid, 0);
      chk({tag, "_quiet_rd_en"}, bus.fifo_rd_en, 0);
    end
  endtask

  initial begin
    bus.fifo_count = '0;
    bus.fifo_rd_data = 6'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    do_reset();
    check_reset_vals();

    // Idle with empty FIFO
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_rd_en", bus.fifo_rd_en, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end

    // Basic table: cell 0=3, cell 16=1, cell 4=1; next table all zero
    for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 2'd0, 2'd0);
    push(1'b0, 1'b1, 2'd2, 2'd1);
    push(1'b1, 1'b0, 2'd1, 2'd1);
    drain(200, "basic");
    push(1'b1, 1'b0, 2'd3, 2'd0);
    drain(200, "zero_table");

    // Missing genotypes only, last flagged on a missing entry
    for (int k = 0; k < 5; k++) push(k == 4, 1'($urandom_range(0, 1)), 2'd3, 2'($urandom_range(0, 3)));
    drain(200, "missing");

    // Back-to-back: last on entries 4 and 5, entries 6-8 plus a flush entry
    push(1'b0, 1'b0, 2'd0, 2'd1);
    push(1'b0, 1'b0, 2'd0, 2'd1);
    push(1'b0, 1'b1, 2'd1, 2'd0);
    push(1'b1, 1'b0, 2'd2, 2'd2);
    push(1'b1, 1'b1, 2'd0, 2'd2);
    push(1'b0, 1'b1, 2'd2, 2'd2);
    push(1'b0, 1'b0, 2'd1, 2'd2);
    push(1'b0, 1'b1, 2'd1, 2'd1);
    push(1'b1, 1'b0, 2'd0, 2'd3);
    drain(300, "b2b");

    // Saturation with 1,0,0,1 backpressure
    ready_mode = 1;
    pat_i = 0;
    em_cycles = 0;
    em_stalls = 0;
    for (int k = 0; k < 20; k++) push(1'b0, 1'b0, 2'd1, 2'd2);
    push(1'b1, 1'b0, 2'd1, 2'd2);
    drain(400, "sat");
    chk("sat_emit_cycles", em_cycles, 18 + em_stalls);
    chk("sat_had_stalls", em_stalls > 0, 1);

    // Randomized traffic
    ready_mode = 2;
    feed_mode = 1;
    for (int k = 0; k < 120; k++) begin
      push($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    push(1'b1, 1'b0, 2'd0, 2'd0);
    drain(6000, "random");

    // Reset during emission at cell 7 with an entry pending
    ready_mode = 0;
    feed_mode = 0;
    for (int k = 0; k < 6; k++) push(k == 5, 1'b0, 2'd0, 2'd1);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b1, 2'd2, 2'd0);
    for (int k = 0; k < 100 && !(bus.out_valid && bus.out_index == 5'd7); k++) step();
    chk("reach_cell7", bus.out_valid && bus.out_index == 5'd7, 1);
    do_reset();
    check_reset_vals();
    push(1'b1, 1'b1, 2'd1, 2'd0);
    drain(200, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/table_fifo_accumulator.md
# table_fifo_accumulator

Downstream drain stage for the table-build FIFO (`FIFOWithCount`) in the BOOST contingency-table path. It pops packed genotype/phenotype entries and accumulates them into an 18-cell 3×3×2 contingency table of saturating counters. On an entry flagged `last` it streams the finished table out, one cell per cycle, with a valid/ready handshake, then clears the table for the next SNP pair.

## Interface
- `DEPTH_WIDTH`, default 3: log2 of the upstream FIFO depth; sets the width of `fifo_count`.
- `CNT_WIDTH`, default 16: width of each cell counter and of `out_count`.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fifo_count` input DEPTH_WIDTH+1: occupancy from the FIFO (registered there).
- `fifo_rd_data` input 6: FIFO read data, valid the cycle after an accepted `fifo_rd_en`. Bit 5 = `last`, bit 4 = `pheno`, bits 3:2 = `gA`, bits 1:0 = `gB`.
- `fifo_rd_en` output 1: pop request to the FIFO.
- `out_valid` output 1: `out_index`/`out_count` hold a table cell.
- `out_ready` input 1: consumer accepts the cell when high together with `out_valid`.
- `out_index` output 5: cell index 0–17.
- `out_count` output CNT_WIDTH: cell value.
- `out_last` output 1: high on cell 17.
- `busy` output 1: high while in EMIT.

## Operation
- Cell index = `pheno`*9 + `gA`*3 + `gB`.
- `gA`==3 or `gB`==3 means missing: no counter changes. The `last` flag on a missing entry still takes effect.
- Counters saturate at 2^CNT_WIDTH−1 and never wrap.
- States:
  - ACCUM: issue pops and accumulate returned entries.
  - EMIT: stream cells 0..17, then return to ACCUM with all counters zero.
- Pop rule (ACCUM only): assert `fifo_rd_en` when `fifo_count` ≥ 2, or when `fifo_count` == 1 and no pop was issued in the previous cycle. `fifo_count` lags a pop by one cycle, so this rule never over-reads. Never pop in EMIT.
- A returned entry with `last`=1 is added to the table first. The state then moves to EMIT on the same edge.
- In-flight entry: a pop issued in the same cycle that the `last` entry returns delivers its data in the first EMIT cycle. That entry is captured in a one-entry pending register and is not applied to the table being emitted.
  - On leaving EMIT, the counters are cleared and the pending entry, if any, is applied to the cleared table.
  - If the pending entry is itself `last`, the block re-enters EMIT immediately, emitting a table holding only that entry.
- EMIT walks `out_index` 0..17. It advances only on `out_valid && out_ready`. `out_count`/`out_index` hold stable while stalled.
- Reset mid-operation: any EMIT in progress is abandoned and the pending entry is discarded. No further pop is issued until after reset is released.

## Timing
- Reset values: `fifo_rd_en`=0, `out_valid`=0, `out_index`=0, `out_count`=0, `out_last`=0, `busy`=0; all counters 0; pending empty; state ACCUM.
- `fifo_rd_en` is registered. The first pop is possible on the cycle after `fifo_count` first reads ≥1.
- Counter update latency: the counter changes on the edge that samples `fifo_rd_data`, which is 2 edges after the edge registering `fifo_rd_en`.
- `out_valid` rises the cycle after the `last` entry is sampled.
- Emission takes 18 cycles minimum with `out_ready` held high. `out_valid` drops the cycle after cell 17 is accepted.
- Throughput: one entry per cycle sustained while `fifo_count` ≥ 2.

## Structure
- Shared package `boost_table_pkg` holds:
  - `NUM_CELLS`=18.
  - `GENO_MISSING`=2'd3.
  - Entry field bit positions (`LAST_BIT`, `PHENO_BIT`, `GA_LSB`, `GB_LSB`).
  - Entry width 6.
  - State encoding.
- One sub-module, `sat_counter_bank`, holds the 18 saturating counters. Its ports are increment-enable, increment-index, clear, read-index and read-data.
- The FSM, pop logic and pending register stay in the top module.

## Test plan
- Reset then idle: `fifo_count`=0 for 20 cycles -> `fifo_rd_en`=0, `out_valid`=0, `busy`=0 throughout.
- Entries (g 0,0,p0)×3, (g 2,1,p1), and last (g 1,1,p0), with `out_ready`=1 -> cells emitted in order: cell 0=3, cell 16=1, cell 4=1, all other cells 0; `out_last` high only on index 17; next table starts all zero.
- Missing genotype: 5 entries with `gA`=3, the last one flagged `last` -> all 18 emitted counts 0, emission still occurs.
- Back-to-back tables: FIFO holds 8 entries with `last` on entries 4 and 5 -> first table holds 4 counts; pending entry 5 yields a second table with exactly 1 count; entries 6–8 land in the third table; no entry is lost or counted twice.
- Backpressure and saturation: `CNT_WIDTH`=4, 20 identical entries plus `last`, `out_ready` toggled 1,0,0,1 -> that cell reads 15; `out_index`/`out_count` stable during stalls; total emission cycles = 18 + stall cycles.
- Reset asserted at EMIT cell 7 with a pending entry -> after reset all outputs are at reset values, counters are zero, and the pending entry is discarded.
